// File: rtl/out_fm_to_store_fifo_if.sv
// Signal bundle between the tile unloader, the out_fm buffer read port and the store stage.
// slave = the unloader itself, master = its environment (controller, buffer, write master).
interface out_fm_to_store_fifo_if #(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int FIFO_AW = 6
);
   logic               unload_start;
   logic               unload_busy;
   logic               unload_done;
   logic [AW-1:0]      out_fm_rd_addr;
   logic               out_fm_rd_ena;
   logic [DW-1:0]      out_fm_rd_data;
   logic [DW-1:0]      store_fifo_data;
   logic               store_fifo_pop;
   logic               store_fifo_empty;
   logic [FIFO_AW:0]   store_fifo_count;

   modport slave (
      input  unload_start, out_fm_rd_data, store_fifo_pop,
      output unload_busy, unload_done, out_fm_rd_addr, out_fm_rd_ena,
             store_fifo_data, store_fifo_empty, store_fifo_count
   );

   modport master (
      output unload_start, out_fm_rd_data, store_fifo_pop,
      input  unload_busy, unload_done, out_fm_rd_addr, out_fm_rd_ena,
             store_fifo_data, store_fifo_empty, store_fifo_count
   );
endinterface

// File: rtl/out_fm_to_store_fifo.sv
// Unloads one Tm x Tr x Tc output tile from the out_fm buffer into a store FIFO,
// issuing buffer reads only when the FIFO is guaranteed to have room for them.
module out_fm_to_store_fifo #(
   parameter int AW         = 16,
   parameter int DW         = 32,
   parameter int Tm         = 16,
   parameter int Tr         = 64,
   parameter int Tc         = 16,
   parameter int FIFO_AW    = 6,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   out_fm_to_store_fifo_if.slave bus_if
);
   localparam int                 TOTAL    = Tm * Tr * Tc;
   localparam logic [AW-1:0]      LAST_IDX = AW'(TOTAL - 1);
   localparam logic [FIFO_AW+1:0] DEPTH_W  = (FIFO_AW+2)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, READ, WAIT} state_e;

   state_e             state_q;
   logic [AW-1:0]      issue_cnt_q;
   logic [AW-1:0]      rd_addr_q;
   logic               rd_ena_q;
   logic               busy_q;
   logic               done_q;

   logic [FIFO_AW-1:0] wr_ptr_q;
   logic [FIFO_AW-1:0] rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic [FIFO_AW:0]   count_d;
   logic               empty_q;
   logic [DW-1:0]      data_q;
   logic [DW-1:0]      fifo_mem [FIFO_DEPTH];

   logic               push;
   logic               pop_ok;
   logic               credit_ok;
   logic [FIFO_AW+1:0] occupancy;

   // Words already queued plus the single read still in flight from the 1-cycle buffer.
   assign occupancy = {1'b0, count_q} + {{(FIFO_AW+1){1'b0}}, rd_ena_q};
   assign credit_ok = occupancy < DEPTH_W;
   assign push      = rd_ena_q;
   assign pop_ok    = bus_if.store_fifo_pop && !empty_q;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         rd_addr_q   <= '0;
         rd_ena_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         rd_ena_q <= 1'b0;
         done_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // A start landing on the done pulse is dropped; the next cycle's start is taken.
               if (bus_if.unload_start && !done_q) begin
                  state_q     <= READ;
                  busy_q      <= 1'b1;
                  issue_cnt_q <= '0;
               end
            end
            READ: begin
               if (credit_ok) begin
                  rd_ena_q    <= 1'b1;
                  rd_addr_q   <= issue_cnt_q;
                  issue_cnt_q <= issue_cnt_q + AW'(1);
                  if (issue_cnt_q == LAST_IDX) state_q <= WAIT;
               end
            end
            WAIT: begin
               if (rd_ena_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: always_comb assigns a default first so no path can infer a latch.
   always_comb begin
      count_d = count_q;
      if (push && !pop_ok)      count_d = count_q + (FIFO_AW+1)'(1);
      else if (!push && pop_ok) count_d = count_q - (FIFO_AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         data_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            data_q   <= fifo_mem[rd_ptr_q];
         end
         count_q <= count_d;
         empty_q <= (count_d == '0);
      end
   end

   // NOTE: storage array has no reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= bus_if.out_fm_rd_data;
   end

   assign bus_if.unload_busy      = busy_q;
   assign bus_if.unload_done      = done_q;
   assign bus_if.out_fm_rd_addr   = rd_addr_q;
   assign bus_if.out_fm_rd_ena    = rd_ena_q;
   assign bus_if.store_fifo_data  = data_q;
   assign bus_if.store_fifo_empty = empty_q;
   assign bus_if.store_fifo_count = count_q;
endmodule

// File: tb/tb_out_fm_to_store_fifo.sv
// Randomised bench for out_fm_to_store_fifo: a queue-based reference model predicts every
// output cycle by cycle from the credit/push/pop rules; scenario tasks compare against it.
module tb_out_fm_to_store_fifo;
   localparam int AW      = 16;
   localparam int DW      = 32;
   localparam int TM      = 4;
   localparam int TR      = 8;
   localparam int TC      = 16;
   localparam int FIFO_AW = 6;
   localparam int DEPTH   = 64;
   localparam int TOTAL   = TM * TR * TC;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   out_fm_to_store_fifo_if #(.AW(AW), .DW(DW), .FIFO_AW(FIFO_AW)) bus ();

   out_fm_to_store_fifo #(
      .AW(AW), .DW(DW), .Tm(TM), .Tr(TR), .Tc(TC), .FIFO_AW(FIFO_AW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   // Buffer returns the word for the registered address while rd_ena is high; junk otherwise.
   logic [DW-1:0] buf_mem [0:(1<<AW)-1];
   assign bus.out_fm_rd_data = bus.out_fm_rd_ena ? buf_mem[bus.out_fm_rd_addr] : 32'hDEAD_BEEF;

   // Reference model: the FIFO is a queue of words, one read may be in flight.
   logic [DW-1:0]    mq [$];
   bit               m_inf = 0, m_inf_last = 0, m_reading = 0;
   bit               m_pop_ok, m_credit, m_push, m_was_busy, m_was_done;
   int               m_issued = 0;
   bit               e_busy = 0, e_done = 0, e_rd_ena = 0, e_empty = 1;
   logic [FIFO_AW:0] e_count = '0;
   logic [DW-1:0]    e_data = '0;
   logic [AW-1:0]    e_addr = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_inf = 0; m_inf_last = 0; m_reading = 0; m_issued = 0;
         e_busy = 0; e_done = 0; e_rd_ena = 0; e_empty = 1;
         e_count = '0; e_data = '0; e_addr = '0;
      end else begin
         m_pop_ok   = bus.store_fifo_pop && (mq.size() != 0);
         m_credit   = (mq.size() + int'(m_inf)) < DEPTH;
         m_push     = m_inf;
         m_was_busy = e_busy;
         m_was_done = e_done;
         if (m_pop_ok) e_data = mq.pop_front();
         if (m_push) mq.push_back(buf_mem[e_addr]);
         e_done = m_push && m_inf_last;
         if (e_done) e_busy = 0;
         m_inf = 0;
         if (m_reading && m_credit) begin
            m_inf      = 1;
            e_addr     = AW'(m_issued);
            m_issued++;
            m_inf_last = (m_issued == TOTAL);
            if (m_inf_last) m_reading = 0;
         end
         if (bus.unload_start && !m_was_busy && !m_was_done) begin
            e_busy = 1; m_reading = 1; m_issued = 0; m_inf_last = 0;
         end
         e_rd_ena = m_inf;
         e_count  = (FIFO_AW+1)'(mq.size());
         e_empty  = (mq.size() == 0);
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      bus.unload_start = 1'b0;
      bus.store_fifo_pop = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_flags busy/done/rd_ena/empty got=%b exp=0001",
                  {bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty});
      end
      checks++;
      if (bus.store_fifo_count !== '0) begin
         errors++; $display("FAIL reset_count got=%0d exp=0", bus.store_fifo_count);
      end
      checks++;
      if (bus.store_fifo_data !== '0 || bus.out_fm_rd_addr !== '0) begin
         errors++;
         $display("FAIL reset_data_addr got data=%h addr=%h exp 0/0", bus.store_fifo_data, bus.out_fm_rd_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_pop_empty();
      bus.store_fifo_pop = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         checks++;
         if (bus.store_fifo_data !== '0 || bus.store_fifo_count !== '0 || bus.store_fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL pop_empty cyc=%0d got data=%h count=%0d empty=%b exp 0/0/1",
                     cyc, bus.store_fifo_data, bus.store_fifo_count, bus.store_fifo_empty);
         end
      end
      bus.store_fifo_pop = 1'b0;
   endtask

   task automatic test_stream();
      int first_rd = -1, last_rd = -1, done_cyc = -1, reads = 0;
      bit finished = 0;
      bus.store_fifo_pop = 1'b1;
      bus.unload_start = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         bus.unload_start = 1'b0;
         checks++;
         if ({bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty} !== {e_busy, e_done, e_rd_ena, e_empty}) begin
            errors++;
            $display("FAIL stream_flags cyc=%0d busy/done/rd_ena/empty got=%b exp=%b", cyc,
                     {bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty}, {e_busy, e_done, e_rd_ena, e_empty});
         end
         checks++;
         if (bus.store_fifo_count !== e_count) begin
            errors++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", cyc, bus.store_fifo_count, e_count);
         end
         checks++;
         if (bus.store_fifo_data !== e_data) begin
            errors++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, bus.store_fifo_data, e_data);
         end
         checks++;
         if (bus.out_fm_rd_addr !== e_addr) begin
            errors++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", cyc, bus.out_fm_rd_addr, e_addr);
         end
         if (bus.out_fm_rd_ena === 1'b1) begin
            reads++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
         end
         if (bus.unload_done === 1'b1) done_cyc = cyc;
         if (done_cyc >= 0 && e_empty) begin finished = 1; break; end
      end
      bus.store_fifo_pop = 1'b0;
      checks++;
      if (!finished) begin errors++; $display("FAIL stream_timeout got done_cyc=%0d exp a done pulse", done_cyc); end
      checks++;
      if (reads != TOTAL) begin errors++; $display("FAIL stream_reads got=%0d exp=%0d", reads, TOTAL); end
      checks++;
      if (last_rd - first_rd + 1 != TOTAL) begin
         errors++; $display("FAIL stream_gaps got span=%0d exp=%0d", last_rd - first_rd + 1, TOTAL);
      end
      checks++;
      if (done_cyc != last_rd + 1) begin
         errors++; $display("FAIL stream_done_time got=%0d exp=%0d", done_cyc, last_rd + 1);
      end
   endtask

   task automatic test_no_pop();
      int reads = 0, after = 0, first = -1;
      bus.store_fifo_pop = 1'b0;
      bus.unload_start = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         bus.unload_start = 1'b0;
         checks++;
         if ({bus.unload_busy, bus.out_fm_rd_ena, bus.store_fifo_empty} !== {e_busy, e_rd_ena, e_empty}
             || bus.store_fifo_count !== e_count || bus.out_fm_rd_addr !== e_addr) begin
            errors++;
            $display("FAIL nopop_state cyc=%0d got busy=%b rd_ena=%b count=%0d addr=%h exp %b/%b/%0d/%h", cyc,
                     bus.unload_busy, bus.out_fm_rd_ena, bus.store_fifo_count, bus.out_fm_rd_addr,
                     e_busy, e_rd_ena, e_count, e_addr);
         end
         if (bus.out_fm_rd_ena === 1'b1) reads++;
      end
      checks++;
      if (reads != DEPTH) begin errors++; $display("FAIL nopop_reads got=%0d exp=%0d", reads, DEPTH); end
      checks++;
      if (bus.store_fifo_count !== (FIFO_AW+1)'(DEPTH)) begin
         errors++; $display("FAIL nopop_count got=%0d exp=%0d", bus.store_fifo_count, DEPTH);
      end
      checks++;
      if (bus.store_fifo_empty !== 1'b0 || bus.out_fm_rd_ena !== 1'b0) begin
         errors++; $display("FAIL nopop_empty_rdena got=%b%b exp=00", bus.store_fifo_empty, bus.out_fm_rd_ena);
      end
      bus.store_fifo_pop = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.store_fifo_pop = 1'b0;
         if (bus.out_fm_rd_ena === 1'b1) begin
            after++;
            if (first < 0) first = k;
         end
      end
      checks++;
      if (after != 1 || first != 1) begin
         errors++; $display("FAIL single_pop_credit got reads=%0d at=%0d exp reads=1 at=1", after, first);
      end
   endtask

   task automatic test_backpressure();
      bit done_seen = 0, finished = 0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         checks++;
         if ({bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty} !== {e_busy, e_done, e_rd_ena, e_empty}) begin
            errors++;
            $display("FAIL bp_flags cyc=%0d busy/done/rd_ena/empty got=%b exp=%b", cyc,
                     {bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty}, {e_busy, e_done, e_rd_ena, e_empty});
         end
         checks++;
         if (bus.store_fifo_count !== e_count || bus.store_fifo_count > (FIFO_AW+1)'(DEPTH)) begin
            errors++; $display("FAIL bp_count cyc=%0d got=%0d exp=%0d", cyc, bus.store_fifo_count, e_count);
         end
         checks++;
         if (bus.store_fifo_data !== e_data) begin
            errors++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, bus.store_fifo_data, e_data);
         end
         checks++;
         if (bus.out_fm_rd_addr !== e_addr) begin
            errors++; $display("FAIL bp_addr cyc=%0d got=%h exp=%h", cyc, bus.out_fm_rd_addr, e_addr);
         end
         if (bus.unload_done === 1'b1) done_seen = 1;
         if (done_seen && e_empty) begin finished = 1; break; end
         bus.store_fifo_pop = (cyc % 3 == 2);
         // Stray starts while busy must not restart the address sequence.
         bus.unload_start = e_busy && ($urandom_range(0, 15) == 0);
      end
      bus.store_fifo_pop = 1'b0;
      bus.unload_start = 1'b0;
      checks++;
      if (!finished) begin errors++; $display("FAIL bp_timeout got done=%b exp done and drained", done_seen); end
   endtask

   task automatic test_back_to_back();
      int dut_dones = 0, model_dones = 0, hold = 1;
      bit second = 0, finished = 0;
      bus.unload_start = 1'b1;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         checks++;
         if ({bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty} !== {e_busy, e_done, e_rd_ena, e_empty}) begin
            errors++;
            $display("FAIL b2b_flags cyc=%0d busy/done/rd_ena/empty got=%b exp=%b", cyc,
                     {bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty}, {e_busy, e_done, e_rd_ena, e_empty});
         end
         checks++;
         if (bus.store_fifo_count !== e_count) begin
            errors++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", cyc, bus.store_fifo_count, e_count);
         end
         checks++;
         if (bus.store_fifo_data !== e_data) begin
            errors++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, bus.store_fifo_data, e_data);
         end
         checks++;
         if (bus.out_fm_rd_addr !== e_addr) begin
            errors++; $display("FAIL b2b_addr cyc=%0d got=%h exp=%h", cyc, bus.out_fm_rd_addr, e_addr);
         end
         if (bus.unload_done === 1'b1) dut_dones++;
         if (e_done) model_dones++;
         if (e_done && !second) begin
            checks++;
            if (bus.store_fifo_empty !== 1'b0) begin
               errors++; $display("FAIL b2b_fifo_nonempty got empty=%b exp=0", bus.store_fifo_empty);
            end
            // Start held across the done cycle (dropped) and the one after (taken); tile B gets fresh data.
            second = 1;
            hold = 2;
            for (int i = 0; i < TOTAL; i++) buf_mem[i] = $urandom;
         end
         if (model_dones == 2 && e_empty) begin finished = 1; break; end
         bus.unload_start = (hold > 0);
         if (hold > 0) hold--;
         bus.store_fifo_pop = 1'($urandom_range(0, 1));
      end
      bus.unload_start = 1'b0;
      bus.store_fifo_pop = 1'b0;
      checks++;
      if (!finished || dut_dones != 2) begin
         errors++; $display("FAIL b2b_tiles got dones=%0d exp=2", dut_dones);
      end
   endtask

   task automatic test_reset_mid();
      int reads = 0;
      int first_addr = -1;
      bit hit = 0, finished = 0;
      bus.unload_start = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         bus.unload_start = 1'b0;
         if (bus.out_fm_rd_ena === 1'b1) reads++;
         if (reads == 100) begin hit = 1; break; end
         bus.store_fifo_pop = 1'($urandom_range(0, 1));
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL rstmid_reach got reads=%0d exp=100", reads); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty} !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_flags busy/done/rd_ena/empty got=%b exp=0001",
                  {bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty});
      end
      checks++;
      if (bus.store_fifo_count !== '0 || bus.store_fifo_data !== '0 || bus.out_fm_rd_addr !== '0) begin
         errors++;
         $display("FAIL rstmid_values got count=%0d data=%h addr=%h exp 0/0/0",
                  bus.store_fifo_count, bus.store_fifo_data, bus.out_fm_rd_addr);
      end
      bus.store_fifo_pop = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.unload_done !== 1'b0 || bus.unload_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_done got done=%b busy=%b exp 0/0", bus.unload_done, bus.unload_busy);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      bus.unload_start = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         bus.unload_start = 1'b0;
         checks++;
         if ({bus.unload_busy, bus.unload_done, bus.out_fm_rd_ena, bus.store_fifo_empty} !== {e_busy, e_done, e_rd_ena, e_empty}
             || bus.store_fifo_count !== e_count || bus.store_fifo_data !== e_data || bus.out_fm_rd_addr !== e_addr) begin
            errors++;
            $display("FAIL rstmid_restart cyc=%0d got busy=%b rd_ena=%b count=%0d data=%h addr=%h exp %b/%b/%0d/%h/%h", cyc,
                     bus.unload_busy, bus.out_fm_rd_ena, bus.store_fifo_count, bus.store_fifo_data, bus.out_fm_rd_addr,
                     e_busy, e_rd_ena, e_count, e_data, e_addr);
         end
         if (bus.out_fm_rd_ena === 1'b1 && first_addr < 0) first_addr = int'(bus.out_fm_rd_addr);
         if (m_inf_last && !e_busy && e_empty) begin finished = 1; break; end
         bus.store_fifo_pop = 1'($urandom_range(0, 1));
      end
      bus.store_fifo_pop = 1'b0;
      checks++;
      if (first_addr != 0 || !finished) begin
         errors++; $display("FAIL rstmid_first_addr got=%0d finished=%b exp 0/1", first_addr, finished);
      end
   endtask

   initial begin
      bus.unload_start = 1'b0;
      bus.store_fifo_pop = 1'b0;
      for (int i = 0; i < TOTAL; i++) buf_mem[i] = $urandom;
      #1;
      test_reset();
      test_pop_empty();
      test_stream();
      test_no_pop();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
